// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl
//   Hazard and flush controller for the 5-stage RISC-V pipeline.
//   - Detects load-use hazards between the ID instruction and a load in ID/EX
//     and stalls for one cycle.
//   - Flushes the younger stages on a taken branch resolved in EX/MEM.
//   - On a SYSTEM instruction, drains the pipeline for DRAIN_CYCLES and then
//     halts until reset.
//   - Counts stall cycles and branch flushes.
// Parameters
//   DRAIN_CYCLES : cycles spent in DRAIN before HALTED (>= 1)
//   CNT_W        : event counter width
// Ports
//   clk, reset          : clock, synchronous active-low reset
//   id_instr            : instruction in IF/ID
//   idex_mem_read       : ID/EX holds a load
//   idex_rd             : ID/EX destination register
//   exmem_branch_taken  : branch in EX/MEM resolved taken
//   pc_write            : PC load enable
//   ifid_write          : IF/ID load enable
//   ifid_flush          : clear IF/ID
//   idex_flush          : bubble into ID/EX
//   exmem_flush         : clear EX/MEM controls
//   halted              : core halted
//   stall_count         : load-use stall cycles
//   flush_count         : taken-branch flushes
// Control outputs are combinational from state and current inputs; state and
// counters update on the rising edge.
module hazard_flush_ctrl #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      id_instr,
   input  logic             idex_mem_read,
   input  logic [4:0]       idex_rd,
   input  logic             exmem_branch_taken,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DLOAD = DW'(DRAIN_CYCLES - 1);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t        state;
   logic [DW-1:0] dcnt;

   logic [6:0] opc;
   logic [4:0] rs1, rs2;
   logic       uses_rs1, uses_rs2, load_use, is_sys;

   // Immediate / funct fields play no part in hazard detection.
   logic unused_bits;
   assign unused_bits = ^{id_instr[31:25], id_instr[14:7]};

   assign opc = id_instr[6:0];
   assign rs1 = id_instr[19:15];
   assign rs2 = id_instr[24:20];

   // U-type and JAL carry immediate bits in the rs1 field; only S/R/B read rs2.
   assign uses_rs1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
   assign uses_rs2 = (opc == OPC_STORE || opc == OPC_OP || opc == OPC_BRANCH);
   assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                     ((uses_rs1 && idex_rd == rs1) || (uses_rs2 && idex_rd == rs2));
   assign is_sys   = (opc == OPC_SYSTEM);

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      halted      = 1'b0;
      if (!reset) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else begin
         case (state)
            RUN, DRAIN: begin
               if (exmem_branch_taken) begin
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
               end else if (state == DRAIN || load_use || is_sys) begin
                  // Hold fetch and bubble ID/EX; SYSTEM itself is never issued.
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  idex_flush = 1'b1;
               end
            end
            default: begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               idex_flush = 1'b1;
               halted     = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= RUN;
         dcnt        <= '0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         case (state)
            RUN: begin
               if (exmem_branch_taken) begin
                  flush_count <= flush_count + 1'b1;
               end else if (load_use) begin
                  stall_count <= stall_count + 1'b1;
               end else if (is_sys) begin
                  dcnt  <= DLOAD;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // A taken branch here means the SYSTEM was on the wrong path.
               if (exmem_branch_taken) begin
                  flush_count <= flush_count + 1'b1;
                  state       <= RUN;
               end else if (dcnt == '0) begin
                  state <= HALTED;
               end else begin
                  dcnt <= dcnt - 1'b1;
               end
            end
            default: state <= HALTED;
         endcase
      end
   end

endmodule
